comparator_4bit: RTL and testbench
==================================

Name: comparator_4bit

Overview:
- Registered magnitude comparator for two WIDTH-bit operands (default 4).
- Each accepted operand pair produces exactly one of three one-hot flags: equal, a_greater, b_greater.
- Also produces the absolute difference and a valid strobe.
- Used as a leaf compare stage in datapath control; one-cycle latency, fully synchronous.

Parameters:
- WIDTH, 4, operand width in bits; legal values 1..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_valid  input  1  operand pair on a/b is accepted this cycle when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- equal  output  1  registered; high when accepted A == B.
- a_greater  output  1  registered; high when accepted A > B.
- b_greater  output  1  registered; high when accepted A < B.
- diff  output  WIDTH  registered |A - B|.
- out_valid  output  1  high for one cycle per accepted pair.

Behaviour:
- Reset: when rst_n == 0 at a rising clk edge, outputs go to:
  - equal = 0, a_greater = 0, b_greater = 0
  - diff = 0, out_valid = 0
- Reset takes priority over in_valid.
- Latency: pair sampled at edge N (in_valid = 1) gives results and out_valid = 1 after edge N, held until edge N+1.
- in_valid = 0 at an edge:
  - out_valid = 0.
  - equal / a_greater / b_greater / diff hold their previous values.
- Back-to-back: in_valid may be high every cycle; each edge yields a new result (throughput 1/cycle). No backpressure.
- Flags after any accepted pair: exactly one of {equal, a_greater, b_greater} is 1.
- Flags after reset (before the first accepted pair): all three are 0.
- Default compare mode is unsigned.
- diff computation:
  - diff = a - b when a >= b, else b - a.
  - Computed in WIDTH+1 bits, truncated to WIDTH.
  - The result always fits in unsigned mode.
- Boundaries:
  - a = b = 0 gives equal = 1, diff = 0.
  - a = 0, b = 2^WIDTH-1 gives b_greater = 1, diff = 2^WIDTH-1.
  - Single-LSB difference gives diff = 1.
- Reset mid-stream: a pair sampled in the same edge as rst_n = 0 is discarded.
- No X propagation: outputs are always driven from registers.

Optional Feature:
- Macro: COMPARATOR_SIGNED_EN.
- Defined:
  - a and b are treated as two's-complement signed values for the flags.
  - diff = |a - b| computed in WIDTH+1 bits and truncated to WIDTH. It is exact when the true difference is ≤ 2^WIDTH-1; this always holds for WIDTH-bit signed operands.
- Undefined: unsigned compare as above.
- Reset, latency and handshake are identical in both modes.

Test Plan:
- Reset check: rst_n = 0 for 2 cycles with in_valid = 1, a = 5, b = 5 -> all flags 0, diff = 0, out_valid = 0.
- Unsigned sequence, in_valid = 1 each cycle, pairs in order (0,15), (5,5), (5,7), (13,13), (13,3), (0,0) -> flags and diff one cycle later:
  - (0,15): b_greater, diff 15.
  - (5,5): equal, diff 0.
  - (5,7): b_greater, diff 2.
  - (13,13): equal, diff 0.
  - (13,3): a_greater, diff 10.
  - (0,0): equal, diff 0.
- Single-LSB toggles, back-to-back pairs (1,0), (1,1), (0,1), (0,0) -> a_greater, equal, b_greater, equal on consecutive cycles; diff 1, 0, 1, 0; out_valid stays 1.
- Hold: accept (13,3), then in_valid = 0 for 3 cycles with a/b changing -> out_valid = 0; a_greater stays 1, diff stays 10.
- Reset mid-stream: rst_n = 0 on the cycle (5,7) is presented -> next cycle all outputs 0; the (5,7) result never appears.
- With COMPARATOR_SIGNED_EN: (13,3), i.e. -3 vs 3 -> b_greater, diff 6. (7,8), i.e. 7 vs -8 -> a_greater, diff 15.

Source files
------------

// File: rtl/comparator_4bit.sv
// rtl/comparator_4bit.sv - registered magnitude comparator with absolute difference
//
// Purpose:
//   Accepts an operand pair (a, b) on any rising clk edge where in_valid is
//   high and, one cycle later, presents exactly one of equal / a_greater /
//   b_greater together with |a - b| and a one-cycle out_valid strobe.
//   Flags and diff hold their last values while in_valid is low.
//
// Configuration:
//   COMPARATOR_SIGNED_EN - when defined, a and b are two's-complement values
//                          for both the flags and diff. When undefined
//                          (default), the compare is unsigned.
//
// Parameters:
//   WIDTH     - operand width in bits, 1..32 (default 4)
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset, wins over in_valid
//   in_valid  in   1      operand pair accepted this edge when high
//   a         in   WIDTH  operand A
//   b         in   WIDTH  operand B
//   equal     out  1      registered, accepted A == B
//   a_greater out  1      registered, accepted A >  B
//   b_greater out  1      registered, accepted A <  B
//   diff      out  WIDTH  registered |A - B|
//   out_valid out  1      one-cycle strobe per accepted pair

module comparator_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             equal,
    output logic             a_greater,
    output logic             b_greater,
    output logic [WIDTH-1:0] diff,
    output logic             out_valid
);

    // Operands widened by one bit so both subtractions are exact in either
    // mode: zero-extension for unsigned, sign-extension for signed.
    logic signed [WIDTH:0] w_a_ext;
    logic signed [WIDTH:0] w_b_ext;
    logic signed [WIDTH:0] w_d_ab;
    logic signed [WIDTH:0] w_d_ba;
    logic                  w_eq;
    logic                  w_a_gt;
    logic                  w_b_gt;
    logic [WIDTH-1:0]      w_diff;

`ifdef COMPARATOR_SIGNED_EN
    assign w_a_ext = {a[WIDTH-1], a};
    assign w_b_ext = {b[WIDTH-1], b};
`else
    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};
`endif

    // With correct extension a single signed compare of the widened values
    // serves both modes.
    assign w_eq   = (w_a_ext == w_b_ext);
    assign w_a_gt = (w_a_ext >  w_b_ext);
    assign w_b_gt = (w_a_ext <  w_b_ext);

    assign w_d_ab = w_a_ext - w_b_ext;
    assign w_d_ba = w_b_ext - w_a_ext;

    // The magnitude never exceeds 2^WIDTH-1, so dropping the top bit is lossless.
    always_comb begin
        w_diff = '0;
        if (w_b_gt) begin
            w_diff = w_d_ba[WIDTH-1:0];
        end else begin
            w_diff = w_d_ab[WIDTH-1:0];
        end
    end

    logic             r_equal;
    logic             r_a_greater;
    logic             r_b_greater;
    logic [WIDTH-1:0] r_diff;
    logic             r_out_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_equal     <= 1'b0;
            r_a_greater <= 1'b0;
            r_b_greater <= 1'b0;
            r_diff      <= '0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_equal     <= w_eq;
            r_a_greater <= w_a_gt;
            r_b_greater <= w_b_gt;
            r_diff      <= w_diff;
            r_out_valid <= 1'b1;
        end else begin
            // Result registers hold; only the strobe drops.
            r_out_valid <= 1'b0;
        end
    end

    assign equal     = r_equal;
    assign a_greater = r_a_greater;
    assign b_greater = r_b_greater;
    assign diff      = r_diff;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_comparator_4bit.sv
// tb/tb_comparator_4bit.sv - self-checking bench for comparator_4bit

module tb_comparator_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         equal;
    logic         a_greater;
    logic         b_greater;
    logic [W-1:0] diff;
    logic         out_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    comparator_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .equal     (equal),
        .a_greater (a_greater),
        .b_greater (b_greater),
        .diff      (diff),
        .out_valid (out_valid)
    );

    typedef struct {
        logic         rst_n;
        logic         in_valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         eq;
        logic         agt;
        logic         bgt;
        logic [W-1:0] diff;
        logic         ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, int av, int bv,
                                logic e, logic ag, logic bg, int d, logic o);
        vec_t t;
        t.rst_n = r; t.in_valid = v;
        t.a = av[W-1:0]; t.b = bv[W-1:0];
        t.eq = e; t.agt = ag; t.bgt = bg;
        t.diff = d[W-1:0]; t.ov = o;
        return t;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(logic r, logic v, logic [W-1:0] av, logic [W-1:0] bv);
        @(negedge clk);
        rst_n = r; in_valid = v; a = av; b = bv;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(string tag, logic e, logic ag, logic bg,
                           logic [W-1:0] d, logic o);
        chk({tag, ".equal"},     int'(equal),     int'(e));
        chk({tag, ".a_greater"}, int'(a_greater), int'(ag));
        chk({tag, ".b_greater"}, int'(b_greater), int'(bg));
        chk({tag, ".diff"},      int'(diff),      int'(d));
        chk({tag, ".out_valid"}, int'(out_valid), int'(o));
    endtask

    // Reference model: operands as plain integers, rules applied directly.
    logic         m_eq, m_agt, m_bgt, m_ov;
    logic [W-1:0] m_diff;

    function automatic int to_int(logic [W-1:0] x);
        int v;
        v = int'(x);
`ifdef COMPARATOR_SIGNED_EN
        if (x[W-1]) v = v - (1 << W);
`endif
        return v;
    endfunction

    task automatic model_edge(logic r, logic v, logic [W-1:0] av, logic [W-1:0] bv);
        int ai, bi, d;
        ai = to_int(av);
        bi = to_int(bv);
        if (!r) begin
            m_eq = 0; m_agt = 0; m_bgt = 0; m_diff = '0; m_ov = 0;
        end else if (v) begin
            m_eq  = (ai == bi);
            m_agt = (ai >  bi);
            m_bgt = (ai <  bi);
            d = (ai >= bi) ? ai - bi : bi - ai;
            m_diff = d[W-1:0];
            m_ov = 1;
        end else begin
            m_ov = 0;
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;

        // reset with a live pair on the inputs
        tbl.push_back(mk(0, 1, 5, 5,   0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 5,   0, 0, 0, 0, 0));
`ifndef COMPARATOR_SIGNED_EN
        tbl.push_back(mk(1, 1, 0, 15,  0, 0, 1, 15, 1));
        tbl.push_back(mk(1, 1, 5, 5,   1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 5, 7,   0, 0, 1, 2, 1));
        tbl.push_back(mk(1, 1, 13, 13, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 13, 3,  0, 1, 0, 10, 1));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 1));
        // single-LSB toggles
        tbl.push_back(mk(1, 1, 1, 0,   0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 1,   1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1,   0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 1));
        // hold while in_valid is low
        tbl.push_back(mk(1, 1, 13, 3,  0, 1, 0, 10, 1));
        tbl.push_back(mk(1, 0, 2, 9,   0, 1, 0, 10, 0));
        tbl.push_back(mk(1, 0, 15, 0,  0, 1, 0, 10, 0));
        tbl.push_back(mk(1, 0, 7, 7,   0, 1, 0, 10, 0));
`else
        tbl.push_back(mk(1, 1, 13, 3,  0, 0, 1, 6, 1));
        tbl.push_back(mk(1, 1, 7, 8,   0, 1, 0, 15, 1));
        tbl.push_back(mk(1, 1, 8, 7,   0, 0, 1, 15, 1));
        tbl.push_back(mk(1, 1, 15, 0,  0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 1, 0, 15,  0, 1, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0,   1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 13, 3,  0, 0, 1, 6, 1));
        tbl.push_back(mk(1, 0, 2, 9,   0, 0, 1, 6, 0));
        tbl.push_back(mk(1, 0, 7, 7,   0, 0, 1, 6, 0));
`endif
        // reset mid-stream discards the (5,7) pair
        tbl.push_back(mk(1, 1, 4, 4,   1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 5, 7,   0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 5, 7,   0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].in_valid, tbl[i].a, tbl[i].b);
            chk_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].agt, tbl[i].bgt,
                    tbl[i].diff, tbl[i].ov);
        end

        // Hand sequence: back-to-back pairs keep out_valid high every cycle
        // and flags stay one-hot.
        step(1, 1, 4'd9, 4'd2);
        step(1, 1, 4'd2, 4'd9);
        chk("b2b.onehot", int'(equal) + int'(a_greater) + int'(b_greater), 1);
        chk("b2b.out_valid", int'(out_valid), 1);

        // Randomized run against the reference model; the table left the
        // model's reset-state view stale, so resynchronise with a reset first.
        step(0, 0, '0, '0);
        model_edge(0, 0, '0, '0);
        for (int i = 0; i < 400; i++) begin
            logic         r, v;
            logic [W-1:0] av, bv;
            r  = ($urandom_range(0, 19) != 0);
            v  = ($urandom_range(0, 3) != 0);
            av = W'($urandom);
            bv = W'($urandom);
            if (i % 7 == 0) bv = av;
            step(r, v, av, bv);
            model_edge(r, v, av, bv);
            chk_all($sformatf("rnd%0d", i), m_eq, m_agt, m_bgt, m_diff, m_ov);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
